c1541_track_loader: RTL and testbench

Track-buffer controller for the 1541 GCR read/write path. It loads the D64 sectors of the current head track from the SD image into the dual-port track buffer RAM. On a track change it first writes back a track that the GCR path has modified, then loads the new track. While the buffer is being filled or flushed it holds ram_ready low, so the GCR datapath stalls and never reads stale data.

---
 rtl/c1541_track_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_c1541_track_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_track_loader.sv
// c1541_track_loader: moves D64 track sectors between the SD image and the
// dual-port track buffer, flushing GCR-modified tracks before a reload.
//
// Ports:
//   clk32, reset            system clock, synchronous active-high reset
//   track                   current head track (1-based)
//   img_mounted             one-cycle pulse: a new image was inserted
//   img_readonly            image is write-protected
//   gcr_we                  GCR path wrote into the buffer (dirty marker)
//   ram_ready, busy         buffer valid / SD transfer in progress
//   sd_lba, sd_rd, sd_wr    sector request towards the host
//   sd_ack, sd_buff_*       host handshake and byte stream
//   buf_addr/din/we/dout    track buffer port B ({sector, byte})

module c1541_track_loader #(
  parameter int SETTLE    = 1024,
  parameter int MAX_TRACK = 40
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        gcr_we,
  output logic        ram_ready,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [12:0] buf_addr,
  output logic [7:0]  buf_din,
  output logic        buf_we,
  input  logic [7:0]  buf_dout
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SET_V = CW'(SETTLE);
  localparam logic [5:0] MAXT = 6'(MAX_TRACK);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_XFER,
    FLUSH_REQ,
    FLUSH_XFER
  } state_t;

  state_t      state, state_n;
  logic [4:0]  sec, sec_n;
  logic [5:0]  tgt, tgt_n;
  logic [5:0]  cur, cur_n;
  logic        dirty, dirty_n;
  logic        mnt, mnt_n;

  logic [5:0]    track_q;
  logic [CW-1:0] cnt;
  logic          req;
  logic          trk_ok;
  logic          cur_ok;
  logic          last;
  logic          xfer_done;
  logic          mnt_any;
  logic          dirty_eff;

  function automatic logic [9:0] base_of(
    input logic [5:0] t
  );
    logic [9:0] tt;
    tt = {4'd0, t};
    if (t <= 6'd17)
      base_of = (tt - 10'd1) * 10'd21;
    else if (t <= 6'd24)
      base_of = 10'd357 + (tt - 10'd18) * 10'd19;
    else if (t <= 6'd30)
      base_of = 10'd490 + (tt - 10'd25) * 10'd18;
    else
      base_of = 10'd598 + (tt - 10'd31) * 10'd17;
  endfunction

  function automatic logic [4:0] count_of(
    input logic [5:0] t
  );
    if (t <= 6'd17)      count_of = 5'd21;
    else if (t <= 6'd24) count_of = 5'd19;
    else if (t <= 6'd30) count_of = 5'd18;
    else                 count_of = 5'd17;
  endfunction

  // Settle timer: a stepping head passes through half-steps, so a new
  // track is only acted on once it has held still for SETTLE cycles.
  always_ff @(posedge clk32) begin
    if (reset) begin
      track_q <= track;
      cnt     <= '0;
    end else begin
      track_q <= track;
      if (track != track_q)
        cnt <= '0;
      else if (cnt != SET_V)
        cnt <= cnt + 1'b1;
    end
  end

  assign req    = (cnt == SET_V) && (track != cur);
  assign trk_ok = (track != 6'd0) && (track <= MAXT);
  assign cur_ok = (cur != 6'd0) && (cur <= MAXT);
  assign last   = (sec == count_of(tgt) - 5'd1);

  assign xfer_done = ((state == LOAD_XFER) ||
                      (state == FLUSH_XFER)) && !sd_ack;
  assign mnt_any   = mnt | img_mounted;

  // A GCR write landing in the same cycle as a request still counts.
  assign dirty_eff = dirty |
                     (gcr_we & ram_ready & ~img_readonly);

  always_ff @(posedge clk32) begin
    if (reset) begin
      state <= IDLE;
      sec   <= '0;
      tgt   <= '0;
      cur   <= '0;
      dirty <= 1'b0;
      mnt   <= 1'b0;
    end else begin
      state <= state_n;
      sec   <= sec_n;
      tgt   <= tgt_n;
      cur   <= cur_n;
      dirty <= dirty_n;
      mnt   <= mnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sec_n   = sec;
    tgt_n   = tgt;
    cur_n   = cur;
    dirty_n = dirty;
    // A mount seen mid-transfer waits for the sector handshake to end.
    mnt_n   = (state != IDLE) && mnt_any && !xfer_done;
    unique case (state)
      IDLE: begin
        dirty_n = dirty_eff;
        if (img_mounted) begin
          if (trk_ok) begin
            state_n = LOAD_REQ;
            sec_n   = '0;
            tgt_n   = track;
          end
        end else if (req) begin
          if (dirty_eff) begin
            state_n = FLUSH_REQ;
            sec_n   = '0;
            tgt_n   = cur;
          end else if (trk_ok) begin
            state_n = LOAD_REQ;
            sec_n   = '0;
            tgt_n   = track;
          end else begin
            cur_n = '0;
          end
        end
      end
      LOAD_REQ: begin
        if (sd_ack) state_n = LOAD_XFER;
      end
      LOAD_XFER: begin
        if (!sd_ack) begin
          if (mnt_any || !last) begin
            state_n = LOAD_REQ;
            sec_n   = sec + 5'd1;
          end else begin
            state_n = IDLE;
            cur_n   = tgt;
            dirty_n = 1'b0;
          end
        end
      end
      FLUSH_REQ: begin
        if (sd_ack) state_n = FLUSH_XFER;
      end
      FLUSH_XFER: begin
        if (!sd_ack) begin
          if (mnt_any || last) begin
            state_n = LOAD_REQ;
            dirty_n = 1'b0;
          end else begin
            state_n = FLUSH_REQ;
            sec_n   = sec + 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Restart a load at sector 0 of the live track after a mount or a
    // completed flush; an unloadable track parks the machine in IDLE.
    if (xfer_done &&
        (mnt_any || (state == FLUSH_XFER && last))) begin
      sec_n = '0;
      tgt_n = track;
      if (!trk_ok) begin
        state_n = IDLE;
        cur_n   = '0;
      end
    end

    if (img_mounted) begin
      dirty_n = 1'b0;
      cur_n   = '0;
    end
  end

  assign ram_ready   = (state == IDLE) && cur_ok;
  assign busy        = (state != IDLE);
  assign sd_rd       = (state == LOAD_REQ);
  assign sd_wr       = (state == FLUSH_REQ);
  assign sd_lba      = busy ?
                       32'(base_of(tgt)) + 32'(sec) : 32'd0;
  assign buf_addr    = {sec, sd_buff_addr};
  assign buf_din     = sd_buff_dout;
  assign buf_we      = (state == LOAD_XFER) && sd_buff_wr;
  assign sd_buff_din = buf_dout;

endmodule

// File: tb/tb_c1541_track_loader.sv
// tb_c1541_track_loader: directed bench with a host model serving
// sector requests and a behavioural model of the track buffer RAM.

module tb_c1541_track_loader;

  localparam int SETTLE = 1024;
  localparam int NB     = 32;

  logic        clk32 = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        img_mounted;
  logic        img_readonly;
  logic        gcr_we;
  logic        ram_ready;
  logic        busy;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [12:0] buf_addr;
  logic [7:0]  buf_din;
  logic        buf_we;
  logic [7:0]  buf_dout;

  always #5 clk32 = ~clk32;

  c1541_track_loader #(
    .SETTLE(SETTLE),
    .MAX_TRACK(40)
  ) dut (
    .clk32(clk32),
    .reset(reset),
    .track(track),
    .img_mounted(img_mounted),
    .img_readonly(img_readonly),
    .gcr_we(gcr_we),
    .ram_ready(ram_ready),
    .busy(busy),
    .sd_lba(sd_lba),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .buf_addr(buf_addr),
    .buf_din(buf_din),
    .buf_we(buf_we),
    .buf_dout(buf_dout)
  );

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  logic [7:0] mem [0:8191];

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'd0;
    buf_dout = 8'd0;
  end

  always @(posedge clk32) begin
    if (buf_we) mem[buf_addr] <= buf_din;
    buf_dout <= mem[buf_addr];
  end

  always @(negedge clk32) begin
    if (!reset) begin
      if (sd_rd && sd_wr) viol++;
      if (busy && ram_ready) viol++;
    end
  end

  function automatic logic [7:0] pat(input int lba, input int a);
    return 8'(lba * 13) ^ 8'(a * 3 + 1);
  endfunction

  bit log_wr[$];
  int log_lba[$];

  // Host: serves one sector per request, logs it, checks flush data.
  initial begin
    bit w;
    int l;
    int bad;
    sd_ack = 1'b0;
    sd_buff_addr = 8'd0;
    sd_buff_dout = 8'd0;
    sd_buff_wr = 1'b0;
    forever begin
      @(posedge clk32); #1;
      if (sd_rd || sd_wr) begin
        w = sd_wr;
        l = int'(sd_lba);
        bad = 0;
        sd_ack = 1'b1;
        @(posedge clk32); #1;
        for (int a = 0; a < NB; a++) begin
          sd_buff_addr = 8'(a);
          if (!w) begin
            sd_buff_dout = pat(l, a);
            sd_buff_wr = 1'b1;
          end
          @(posedge clk32); #1;
          if (w && sd_buff_din !== pat(l, a)) bad++;
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        if (w) begin
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL wrdata lba=%0d bad_bytes=%0d required=0",
                     l, bad);
          end
        end
        log_wr.push_back(w);
        log_lba.push_back(l);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk32); #1;
    end
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    log_wr.delete();
    log_lba.delete();
  endtask

  task automatic wait_ready(input int n, input int limit,
                            input string nm);
    int c;
    c = 0;
    while (!(ram_ready && log_lba.size() >= n) && c < limit) begin
      tick(1);
      c++;
    end
    chk(nm, c < limit, 1);
  endtask

  task automatic check_seq(input string nm, input int start,
                           input int n, input bit w, input int base);
    int bad;
    bad = 0;
    if (log_lba.size() < start + n) begin
      bad = n;
    end else begin
      for (int i = 0; i < n; i++)
        if (log_wr[start+i] != w || log_lba[start+i] != base + i)
          bad++;
    end
    chk(nm, bad, 0);
  endtask

  task automatic gcr_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      gcr_we = 1'b1;
      tick(1);
      gcr_we = 1'b0;
      tick(2);
    end
  endtask

  typedef struct {
    logic [5:0] trk;
    int         n;
    int         base;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int c;
    tbl[0] = '{6'd18, 19, 357};
    tbl[1] = '{6'd1,  21, 0};
    tbl[2] = '{6'd17, 21, 336};
    tbl[3] = '{6'd24, 19, 471};
    tbl[4] = '{6'd25, 18, 490};
    tbl[5] = '{6'd30, 18, 580};
    tbl[6] = '{6'd31, 17, 598};
    tbl[7] = '{6'd40, 17, 751};
    tbl[8] = '{6'd0,  0,  0};
    tbl[9] = '{6'd41, 0,  0};

    reset = 1'b1;
    track = 6'd18;
    img_mounted = 1'b0;
    img_readonly = 1'b0;
    gcr_we = 1'b0;
    tick(3);
    chk("rst_ready", ram_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_buf_we", buf_we, 0);
    chk("rst_lba", sd_lba, 0);
    reset = 1'b0;
    tick(SETTLE - 50);
    chk("early_req", log_lba.size(), 0);

    for (int i = 0; i < 10; i++) begin
      clr_log();
      track = tbl[i].trk;
      if (tbl[i].n > 0)
        wait_ready(tbl[i].n, SETTLE + 2000, "load_tmo");
      else
        tick(SETTLE + 300);
      chk("nreq", log_lba.size(), tbl[i].n);
      if (tbl[i].n > 0)
        check_seq("rdseq", 0, tbl[i].n, 1'b0, tbl[i].base);
      chk("ready", ram_ready, tbl[i].n > 0);
      if (tbl[i].trk == 6'd18)
        chk("buf3_10", mem[13'h310], pat(360, 16));
    end

    // dirty track 18 is flushed, then track 19 loaded
    clr_log();
    track = 6'd18;
    wait_ready(19, SETTLE + 2000, "t18_tmo");
    gcr_pulses(5);
    clr_log();
    track = 6'd19;
    wait_ready(38, SETTLE + 4000, "flush_tmo");
    chk("flush_n", log_lba.size(), 38);
    check_seq("flush_wr", 0, 19, 1'b1, 357);
    check_seq("flush_rd", 19, 19, 1'b0, 376);

    // read-only image never gets written
    img_readonly = 1'b1;
    gcr_pulses(5);
    clr_log();
    track = 6'd20;
    wait_ready(19, SETTLE + 2000, "ro_tmo");
    chk("ro_n", log_lba.size(), 19);
    check_seq("ro_rd", 0, 19, 1'b0, 395);
    img_readonly = 1'b0;

    // stepper jitter shorter than SETTLE is ignored
    clr_log();
    for (int k = 0; k < 4; k++) begin
      track = (k % 2 == 0) ? 6'd19 : 6'd20;
      tick(500);
    end
    chk("toggle_nreq", log_lba.size(), 0);
    track = 6'd19;
    c = 0;
    while (!sd_rd && c < SETTLE + 200) begin
      tick(1);
      c++;
    end
    chk("settle_lo", c >= SETTLE - 5, 1);
    chk("settle_hi", c <= SETTLE + 10, 1);
    wait_ready(19, 2000, "settle_tmo");
    check_seq("settle_rd", 0, 19, 1'b0, 376);

    // mount during flush of sector 7
    gcr_pulses(3);
    clr_log();
    track = 6'd20;
    c = 0;
    while (!(sd_ack && log_lba.size() == 7) && c < SETTLE + 2000) begin
      tick(1);
      c++;
    end
    chk("mnt_reach", c < SETTLE + 2000, 1);
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    wait_ready(27, 3000, "mnt_tmo");
    chk("mnt_n", log_lba.size(), 27);
    check_seq("mnt_wr", 0, 8, 1'b1, 376);
    check_seq("mnt_rd", 8, 19, 1'b0, 395);

    // dirty was discarded: next track change only reads
    clr_log();
    track = 6'd21;
    wait_ready(19, SETTLE + 2000, "post_tmo");
    chk("post_n", log_lba.size(), 19);
    check_seq("post_rd", 0, 19, 1'b0, 414);

    // mount in IDLE reloads immediately
    clr_log();
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    chk("mnt_idle_rd", sd_rd, 1);
    chk("mnt_idle_rdy", ram_ready, 0);
    wait_ready(19, 2000, "mnt_idle_tmo");
    check_seq("mnt_idle_seq", 0, 19, 1'b0, 414);

    // reset in the middle of a load data phase
    clr_log();
    track = 6'd22;
    c = 0;
    while (!(sd_ack && busy && log_lba.size() == 2) &&
           c < SETTLE + 2000) begin
      tick(1);
      c++;
    end
    chk("rst_reach", c < SETTLE + 2000, 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_rd", sd_rd, 0);
    chk("mid_rst_we", buf_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lba", sd_lba, 0);
    tick(1);
    reset = 1'b0;
    c = 0;
    while (sd_ack && c < 200) begin
      tick(1);
      c++;
    end
    tick(2);
    clr_log();
    wait_ready(19, SETTLE + 2000, "reload_tmo");
    chk("reload_n", log_lba.size(), 19);
    check_seq("reload_rd", 0, 19, 1'b0, 433);

    chk("proto_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
